// File: rtl/channel_fifo_pkg.sv
// rtl/channel_fifo_pkg.sv - shared width helper for the channel FIFO
package channel_fifo_pkg;

  // Ceiling log2 usable in parameter context; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/channel_fifo_if.sv
// rtl/channel_fifo_if.sv - valid/data-acknowledge channel bundle
interface channel_fifo_if #(
  parameter int N = 8
);
  logic         v;
  logic [N-1:0] d;
  logic         a;

  // Producer drives valid and data, consumer answers with acknowledge.
  modport master (output v, output d, input a);
  modport slave  (input v, input d, output a);
endinterface

// File: rtl/channel_fifo_storage.sv
// rtl/channel_fifo_storage.sv - register array with one write port and async read
module channel_fifo_storage #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  // Write port; contents are deliberately left unreset since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/channel_fifo.sv
// rtl/channel_fifo.sv - channel-to-channel FIFO with occupancy output
module channel_fifo
  import channel_fifo_pkg::*;
#(
  parameter int N     = -1,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  channel_fifo_if.slave               in,
  channel_fifo_if.master              out,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [N-1:0]  rdata;

  // Occupancy alone decides full/empty, so the pointers never need an extra wrap bit.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Acceptance depends only on in.v and registered state: a full FIFO refuses even
  // when the consumer is popping this cycle, keeping out.a off the in.a path.
  assign push  = in.v && !full;
  assign pop   = !empty && out.a;

  assign in.a  = push;
  assign out.v = !empty;
  assign out.d = rdata;

  channel_fifo_storage #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wp),
    .wdata (in.d),
    .raddr (rp),
    .rdata (rdata)
  );

  // Pointer and occupancy update; pointers wrap modulo DEPTH by width alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_fifo.sv
// tb/tb_channel_fifo.sv - scoreboard bench for channel_fifo
module tb_channel_fifo;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [2:0] count;

  channel_fifo_if #(.N(N)) in_if ();
  channel_fifo_if #(.N(N)) out_if ();

  channel_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in_if),
    .out   (out_if),
    .count (count)
  );

  int total_checks;
  int passed_checks;

  // Reference model: a plain queue of accepted words and an occupancy number.
  logic [N-1:0] exp_q [$];
  int           occ;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_checks++;
    if (act === req) passed_checks++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // Model: at each edge, a word offered while the model has room is accepted, and
  // a word leaves whenever the model holds one and the consumer acknowledges.
  always @(posedge clk) begin
    if (!reset) begin
      automatic bit acc = in_if.v && (occ < DEPTH);
      automatic bit pp  = (occ > 0) && out_if.a;
      if (acc) exp_q.push_back(in_if.d);
      occ = occ + int'(acc) - int'(pp);
    end
  end

  // Monitor: mid-cycle, compare handshake, occupancy and any word being handed over.
  always @(negedge clk) begin
    chk("in_a",  32'(in_if.a),  32'(in_if.v && (occ < DEPTH) && !reset));
    chk("out_v", 32'(out_if.v), 32'(occ > 0));
    chk("count", 32'(count),    32'(occ));
    if (out_if.v && out_if.a) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(out_if.d), 32'hffff_ffff);
      end else begin
        automatic logic [N-1:0] w = exp_q.pop_front();
        chk("out_d", 32'(out_if.d), 32'(w));
      end
    end
  end

  // Apply inputs #1 after an edge, then let one full cycle run.
  task automatic drive(input logic v, input logic [N-1:0] d, input logic a);
    in_if.v  = v;
    in_if.d  = d;
    out_if.a = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    occ           = 0;
    in_if.v  = 1'b0;
    in_if.d  = '0;
    out_if.a = 1'b0;
    reset    = 1'b1;
    #1;
    chk("reset_out_v", 32'(out_if.v), 32'd0);
    chk("reset_in_a",  32'(in_if.a),  32'd0);
    chk("reset_count", 32'(count),    32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle with a stray acknowledge: nothing may move.
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    chk("idle_count", 32'(count), 32'd0);

    // Single word: visible the cycle after acceptance, then drained.
    drive(1'b1, 8'h11, 1'b0);
    chk("single_out_v", 32'(out_if.v), 32'd1);
    chk("single_out_d", 32'(out_if.d), 32'h11);
    chk("single_count", 32'(count),    32'd1);
    drive(1'b0, 8'h00, 1'b1);
    chk("single_drained", 32'(count), 32'd0);

    // Fill to DEPTH, offer one more while full, then pop one and retry.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0);
    chk("fill_count", 32'(count), 32'd4);
    in_if.v  = 1'b1;
    in_if.d  = 8'hA4;
    out_if.a = 1'b1;
    #1;
    chk("full_in_a_with_out_a", 32'(in_if.a), 32'd0);
    chk("full_head", 32'(out_if.d), 32'hA0);
    @(posedge clk);
    #1;
    drive(1'b1, 8'hA4, 1'b0);
    chk("refill_count", 32'(count), 32'd4);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 8'h00, 1'b1);
    chk("fill_drained", 32'(count), 32'd0);

    // Streaming at full rate: occupancy holds at one, pointers wrap repeatedly.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      chk("stream_out_d", 32'(out_if.d), 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    drive(1'b0, 8'h00, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Drain, load three words, then reset mid-cycle.
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 3; i++) drive(1'b1, 8'(i), 1'b0);
    chk("pre_reset_count", 32'(count), 32'd3);
    in_if.v  = 1'b0;
    out_if.a = 1'b0;
    #2;
    reset = 1'b1;
    exp_q.delete();
    occ = 0;
    #1;
    chk("async_reset_out_v", 32'(out_if.v), 32'd0);
    chk("async_reset_count", 32'(count),    32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 8'h5A, 1'b0);
    chk("post_reset_out_v", 32'(out_if.v), 32'd1);
    chk("post_reset_out_d", 32'(out_if.d), 32'h5A);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("final_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
